// File: rtl/puan_tablosu_denetleyici.sv
// Decode-stage scoreboard for multi-cycle units. It tracks pending int/fp destinations,
// stalls on hazards, issues start pulses and arbitrates the writeback port round-robin.
// Optional stall counter: define PUAN_TABLOSU_SAYAC_EN.
module puan_tablosu_denetleyici #(
  parameter int unsigned BIRIM_SAYISI = 2,
  parameter int unsigned BIRIM_BIT    = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      coz_gecerli_i,
  input  logic [4:0]                coz_rs1_adres_i,
  input  logic                      coz_rs1_oku_i,
  input  logic                      coz_rs1_fp_i,
  input  logic [4:0]                coz_rs2_adres_i,
  input  logic                      coz_rs2_oku_i,
  input  logic                      coz_rs2_fp_i,
  input  logic [4:0]                coz_rs3_adres_i,
  input  logic                      coz_rs3_oku_i,
  input  logic [4:0]                coz_rd_adres_i,
  input  logic                      coz_rd_yaz_i,
  input  logic                      coz_rd_fp_i,
  input  logic                      coz_cok_cevrim_i,
  input  logic [BIRIM_BIT-1:0]      coz_birim_i,
  input  logic                      dallanma_gerceklesti_i,
  input  logic [BIRIM_SAYISI-1:0]   birim_mesgul_i,
  input  logic [BIRIM_SAYISI-1:0]   birim_sonuc_gecerli_i,
  input  logic [5*BIRIM_SAYISI-1:0] birim_rd_adres_i,
  input  logic [BIRIM_SAYISI-1:0]   birim_rd_fp_i,
  input  logic                      gy_bos_i,
  output logic                      coz_durdur_o,
  output logic [BIRIM_SAYISI-1:0]   birim_baslat_o,
  output logic [BIRIM_SAYISI-1:0]   birim_sonuc_kabul_o,
  output logic                      gy_yaz_o,
  output logic [BIRIM_BIT-1:0]      gy_birim_o,
  output logic [31:0]               bekleyen_int_o,
  output logic [31:0]               bekleyen_fp_o
`ifdef PUAN_TABLOSU_SAYAC_EN
  ,
  output logic [31:0]               durdurma_sayaci_o
`endif
);

  localparam int unsigned N  = BIRIM_SAYISI;
  localparam int unsigned AW = 5;

  logic [31:0]          int_q, int_d, fp_q, fp_d;
  logic [BIRIM_BIT-1:0] rr_q, rr_d;
  logic                 raw, waw, yapisal, birim_var, verilir;
  logic [AW-1:0]        temizle_adres;
  logic                 temizle_fp;
  int unsigned          idx;

  function automatic logic beklemede(input logic [AW-1:0] a, input logic fp,
                                     input logic [31:0] bi, input logic [31:0] bf);
    if (fp) return bf[a];
    return (a != 5'd0) && bi[a];
  endfunction

  // Hazard detection and issue, purely from registered bitmaps
  always_comb begin
    birim_var = 32'(coz_birim_i) < N;
    raw = (coz_rs1_oku_i && beklemede(coz_rs1_adres_i, coz_rs1_fp_i, int_q, fp_q)) ||
          (coz_rs2_oku_i && beklemede(coz_rs2_adres_i, coz_rs2_fp_i, int_q, fp_q)) ||
          (coz_rs3_oku_i && beklemede(coz_rs3_adres_i, 1'b1, int_q, fp_q));
    waw = coz_rd_yaz_i && beklemede(coz_rd_adres_i, coz_rd_fp_i, int_q, fp_q);
    yapisal = coz_cok_cevrim_i &&
              (!birim_var || birim_mesgul_i[coz_birim_i] || birim_sonuc_gecerli_i[coz_birim_i]);
    coz_durdur_o = coz_gecerli_i && (raw || waw || yapisal);
    verilir = coz_gecerli_i && !coz_durdur_o && coz_cok_cevrim_i && !dallanma_gerceklesti_i;
    birim_baslat_o = '0;
    if (verilir) birim_baslat_o[coz_birim_i] = 1'b1;
  end

  // Round-robin writeback grant, only when the single-cycle pipeline leaves the port free
  always_comb begin
    birim_sonuc_kabul_o = '0;
    gy_yaz_o            = 1'b0;
    gy_birim_o          = '0;
    temizle_adres       = '0;
    temizle_fp          = 1'b0;
    idx                 = 0;
    if (gy_bos_i) begin
      for (int unsigned i = 0; i < N; i++) begin
        idx = (32'(rr_q) + i) % N;
        if (!gy_yaz_o && birim_sonuc_gecerli_i[idx]) begin
          gy_yaz_o                 = 1'b1;
          birim_sonuc_kabul_o[idx] = 1'b1;
          gy_birim_o               = BIRIM_BIT'(idx);
          temizle_adres            = birim_rd_adres_i[AW*idx +: AW];
          temizle_fp               = birim_rd_fp_i[idx];
        end
      end
    end
  end

  // Next bitmap state: clear from writeback first so a same-edge set wins
  always_comb begin
    int_d = int_q;
    fp_d  = fp_q;
    rr_d  = rr_q;
    if (gy_yaz_o) begin
      if (temizle_fp) fp_d[temizle_adres] = 1'b0;
      else            int_d[temizle_adres] = 1'b0;
      rr_d = BIRIM_BIT'((32'(gy_birim_o) + 1) % N);
    end
    if (verilir && coz_rd_yaz_i) begin
      if (coz_rd_fp_i)                  fp_d[coz_rd_adres_i]  = 1'b1;
      else if (coz_rd_adres_i != 5'd0)  int_d[coz_rd_adres_i] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      int_q <= '0;
      fp_q  <= '0;
      rr_q  <= '0;
    end else begin
      int_q <= int_d;
      fp_q  <= fp_d;
      rr_q  <= rr_d;
    end
  end

  assign bekleyen_int_o = int_q;
  assign bekleyen_fp_o  = fp_q;

`ifdef PUAN_TABLOSU_SAYAC_EN
  logic [31:0] sayac_q;

  // Saturating count of stalled decode cycles
  always_ff @(posedge clk_i) begin
    if (!rst_ni)                             sayac_q <= '0;
    else if (coz_durdur_o && sayac_q != '1)  sayac_q <= sayac_q + 32'd1;
  end

  assign durdurma_sayaci_o = sayac_q;
`endif

endmodule

// File: tb/tb_puan_tablosu_denetleyici.sv
// Directed bench for puan_tablosu_denetleyici with a FIFO scoreboard of expected values.
module tb_puan_tablosu_denetleyici;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       coz_gecerli_i, coz_rs1_oku_i, coz_rs1_fp_i, coz_rs2_oku_i, coz_rs2_fp_i;
  logic       coz_rs3_oku_i, coz_rd_yaz_i, coz_rd_fp_i, coz_cok_cevrim_i;
  logic [4:0] coz_rs1_adres_i, coz_rs2_adres_i, coz_rs3_adres_i, coz_rd_adres_i;
  logic [0:0] coz_birim_i;
  logic       dallanma_gerceklesti_i, gy_bos_i;
  logic [1:0] birim_mesgul_i, birim_sonuc_gecerli_i, birim_rd_fp_i;
  logic [9:0] birim_rd_adres_i;
  logic       coz_durdur_o, gy_yaz_o;
  logic [1:0] birim_baslat_o, birim_sonuc_kabul_o;
  logic [0:0] gy_birim_o;
  logic [31:0] bekleyen_int_o, bekleyen_fp_o;
`ifdef PUAN_TABLOSU_SAYAC_EN
  logic [31:0] durdurma_sayaci_o;
`endif

  always #5 clk_i = ~clk_i;

  puan_tablosu_denetleyici #(.BIRIM_SAYISI(2), .BIRIM_BIT(1)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .coz_gecerli_i(coz_gecerli_i),
    .coz_rs1_adres_i(coz_rs1_adres_i), .coz_rs1_oku_i(coz_rs1_oku_i), .coz_rs1_fp_i(coz_rs1_fp_i),
    .coz_rs2_adres_i(coz_rs2_adres_i), .coz_rs2_oku_i(coz_rs2_oku_i), .coz_rs2_fp_i(coz_rs2_fp_i),
    .coz_rs3_adres_i(coz_rs3_adres_i), .coz_rs3_oku_i(coz_rs3_oku_i),
    .coz_rd_adres_i(coz_rd_adres_i), .coz_rd_yaz_i(coz_rd_yaz_i), .coz_rd_fp_i(coz_rd_fp_i),
    .coz_cok_cevrim_i(coz_cok_cevrim_i), .coz_birim_i(coz_birim_i),
    .dallanma_gerceklesti_i(dallanma_gerceklesti_i),
    .birim_mesgul_i(birim_mesgul_i), .birim_sonuc_gecerli_i(birim_sonuc_gecerli_i),
    .birim_rd_adres_i(birim_rd_adres_i), .birim_rd_fp_i(birim_rd_fp_i),
    .gy_bos_i(gy_bos_i),
    .coz_durdur_o(coz_durdur_o), .birim_baslat_o(birim_baslat_o),
    .birim_sonuc_kabul_o(birim_sonuc_kabul_o), .gy_yaz_o(gy_yaz_o), .gy_birim_o(gy_birim_o),
    .bekleyen_int_o(bekleyen_int_o), .bekleyen_fp_o(bekleyen_fp_o)
`ifdef PUAN_TABLOSU_SAYAC_EN
    , .durdurma_sayaci_o(durdurma_sayaci_o)
`endif
  );

  typedef struct {
    string       tag;
    logic [31:0] v;
  } beklenen_t;

  beklenen_t sb[$];
  int n_pass  = 0;
  int n_total = 0;

  task automatic bekle(input string t, input logic [31:0] v);
    beklenen_t e;
    e.tag = t;
    e.v   = v;
    sb.push_back(e);
  endtask

  task automatic kontrol(input logic [31:0] obs);
    beklenen_t e;
    n_total++;
    assert (sb.size() != 0) else $error("FAIL sb_empty observed=%h expected=none", obs);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    assert (obs === e.v) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.v);
  endtask

  task automatic coz(input logic g, input logic [4:0] rs1, input logic o1,
                     input logic [4:0] rs2, input logic o2, input logic [4:0] rd,
                     input logic yaz, input logic rdfp, input logic cok, input logic b);
    coz_gecerli_i = g;
    coz_rs1_adres_i = rs1; coz_rs1_oku_i = o1; coz_rs1_fp_i = 1'b0;
    coz_rs2_adres_i = rs2; coz_rs2_oku_i = o2; coz_rs2_fp_i = 1'b0;
    coz_rs3_adres_i = 5'd0; coz_rs3_oku_i = 1'b0;
    coz_rd_adres_i = rd; coz_rd_yaz_i = yaz; coz_rd_fp_i = rdfp;
    coz_cok_cevrim_i = cok; coz_birim_i = b;
    dallanma_gerceklesti_i = 1'b0;
  endtask

  task automatic birimler(input logic [1:0] mesgul, input logic [1:0] gecerli,
                          input logic [4:0] rd0, input logic [4:0] rd1,
                          input logic [1:0] fp, input logic bos);
    birim_mesgul_i = mesgul;
    birim_sonuc_gecerli_i = gecerli;
    birim_rd_adres_i = {rd1, rd0};
    birim_rd_fp_i = fp;
    gy_bos_i = bos;
  endtask

  task automatic adim();
    @(negedge clk_i);
  endtask

  initial begin
    rst_ni = 1'b0;
    coz(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    birimler(2'b00, 2'b00, 5'd0, 5'd0, 2'b00, 1'b0);
    repeat (2) @(posedge clk_i);

    // Reset state
    adim(); rst_ni = 1'b1; #1;
    bekle("rst_int", 32'h0);  kontrol(bekleyen_int_o);
    bekle("rst_fp", 32'h0);   kontrol(bekleyen_fp_o);
    bekle("rst_stall", 32'h0); kontrol(32'(coz_durdur_o));
    bekle("rst_start", 32'h0); kontrol(32'(birim_baslat_o));
    bekle("rst_grant", 32'h0); kontrol(32'(birim_sonuc_kabul_o));
    bekle("rst_wb", 32'h0);   kontrol(32'(gy_yaz_o));

    // div x5 -> unit0, then add x6,x5,x1 stalls until after the grant
    adim(); coz(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0); #1;
    bekle("div_stall", 32'h0);  kontrol(32'(coz_durdur_o));
    bekle("div_start", 32'h1);  kontrol(32'(birim_baslat_o));
    bekle("div_set_x5", 32'h20);
    adim(); birimler(2'b01, 2'b00, 5'd5, 5'd0, 2'b00, 1'b0);
    coz(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0); #1;
    kontrol(bekleyen_int_o);
    bekle("raw_stall1", 32'h1); kontrol(32'(coz_durdur_o));
    bekle("raw_nostart", 32'h0); kontrol(32'(birim_baslat_o));
    adim(); #1;
    bekle("raw_stall2", 32'h1); kontrol(32'(coz_durdur_o));
    bekle("raw_pend", 32'h20);  kontrol(bekleyen_int_o);
    adim(); birimler(2'b00, 2'b01, 5'd5, 5'd0, 2'b00, 1'b1); #1;
    bekle("wb0_grant", 32'h1);  kontrol(32'(birim_sonuc_kabul_o));
    bekle("wb0_yaz", 32'h1);    kontrol(32'(gy_yaz_o));
    bekle("wb0_unit", 32'h0);   kontrol(32'(gy_birim_o));
    bekle("wb0_stall", 32'h1);  kontrol(32'(coz_durdur_o));
    bekle("wb0_clear", 32'h0);
    adim(); birimler(2'b00, 2'b00, 5'd0, 5'd0, 2'b00, 1'b0); #1;
    kontrol(bekleyen_int_o);
    bekle("raw_release", 32'h0); kontrol(32'(coz_durdur_o));

    // Multi-cycle op to x0 then a read of x0
    adim(); coz(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1); #1;
    bekle("x0_start", 32'h2);   kontrol(32'(birim_baslat_o));
    bekle("x0_noset", 32'h0);
    adim(); coz(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0); #1;
    kontrol(bekleyen_int_o);
    bekle("x0_nostall", 32'h0); kontrol(32'(coz_durdur_o));

    // fmadd f3 on unit1; int x3 read is not a hazard, fp rs3=f3 is
    adim(); coz(1'b1, 5'd1, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b1, 1'b1); #1;
    bekle("fma_start", 32'h2);  kontrol(32'(birim_baslat_o));
    bekle("fma_fp", 32'h8);
    bekle("fma_int", 32'h0);
    adim(); birimler(2'b10, 2'b00, 5'd0, 5'd3, 2'b10, 1'b0);
    coz(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0); #1;
    kontrol(bekleyen_fp_o);
    kontrol(bekleyen_int_o);
    bekle("int_x3_nostall", 32'h0); kontrol(32'(coz_durdur_o));
    adim(); coz_rs3_adres_i = 5'd3; coz_rs3_oku_i = 1'b1; #1;
    bekle("fp_f3_stall", 32'h1); kontrol(32'(coz_durdur_o));
    adim(); birimler(2'b00, 2'b10, 5'd0, 5'd3, 2'b10, 1'b1); #1;
    bekle("wb1_grant", 32'h2);  kontrol(32'(birim_sonuc_kabul_o));
    bekle("wb1_unit", 32'h1);   kontrol(32'(gy_birim_o));
    bekle("wb1_stall", 32'h1);  kontrol(32'(coz_durdur_o));
    bekle("wb1_clear", 32'h0);
    adim(); birimler(2'b00, 2'b00, 5'd0, 5'd0, 2'b00, 1'b0); #1;
    kontrol(bekleyen_fp_o);
    bekle("fp_release", 32'h0); kontrol(32'(coz_durdur_o));

    // Both units valid: no grant without a free port, then alternate
    adim(); coz(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    birimler(2'b00, 2'b11, 5'd20, 5'd21, 2'b00, 1'b0); #1;
    bekle("busy_port_grant", 32'h0); kontrol(32'(birim_sonuc_kabul_o));
    bekle("busy_port_yaz", 32'h0);   kontrol(32'(gy_yaz_o));
    adim(); gy_bos_i = 1'b1; #1;
    bekle("rr_first", 32'h1);   kontrol(32'(birim_sonuc_kabul_o));
    bekle("rr_first_u", 32'h0); kontrol(32'(gy_birim_o));
    adim(); #1;
    bekle("rr_second", 32'h2);  kontrol(32'(birim_sonuc_kabul_o));
    bekle("rr_second_u", 32'h1); kontrol(32'(gy_birim_o));
    adim(); #1;
    bekle("rr_third", 32'h1);   kontrol(32'(birim_sonuc_kabul_o));

    // Taken branch cancels the issue
    adim(); birimler(2'b00, 2'b00, 5'd0, 5'd0, 2'b00, 1'b0);
    coz(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0);
    dallanma_gerceklesti_i = 1'b1; #1;
    bekle("br_nostart", 32'h0); kontrol(32'(birim_baslat_o));
    bekle("br_nostall", 32'h0); kontrol(32'(coz_durdur_o));
    bekle("br_nobit", 32'h0);
    adim(); coz(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); #1;
    kontrol(bekleyen_int_o);

    // Structural stall while unit0 busy or holding a result
    adim(); birimler(2'b01, 2'b00, 5'd22, 5'd0, 2'b00, 1'b0);
    coz(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0); #1;
    bekle("str_busy_stall", 32'h1); kontrol(32'(coz_durdur_o));
    bekle("str_busy_nostart", 32'h0); kontrol(32'(birim_baslat_o));
    adim(); birimler(2'b00, 2'b01, 5'd22, 5'd0, 2'b00, 1'b0); #1;
    bekle("str_valid_stall", 32'h1); kontrol(32'(coz_durdur_o));
    adim(); birimler(2'b00, 2'b00, 5'd0, 5'd0, 2'b00, 1'b0); #1;
    bekle("str_free_stall", 32'h0); kontrol(32'(coz_durdur_o));
    bekle("str_free_start", 32'h1); kontrol(32'(birim_baslat_o));
    bekle("str_set_x9", 32'h200);
    adim(); coz(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); #1;
    kontrol(bekleyen_int_o);

    // Same-edge clear and set of x10: set wins
    adim(); birimler(2'b00, 2'b01, 5'd10, 5'd0, 2'b00, 1'b1);
    coz(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0, 1'b1, 1'b1); #1;
    bekle("sc_grant", 32'h1);   kontrol(32'(birim_sonuc_kabul_o));
    bekle("sc_start", 32'h2);   kontrol(32'(birim_baslat_o));
    bekle("sc_set_wins", 32'h600);
    adim(); birimler(2'b00, 2'b00, 5'd0, 5'd0, 2'b00, 1'b0);
    coz(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0); #1;
    kontrol(bekleyen_int_o);
    bekle("waw_stall", 32'h1);  kontrol(32'(coz_durdur_o));

    // Mid-operation reset clears the bitmaps
    adim(); rst_ni = 1'b0;
    coz(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    bekle("mid_rst_int", 32'h0);
    adim(); rst_ni = 1'b1; #1;
    kontrol(bekleyen_int_o);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
